multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Moore-style sequencer for the multi-cycle MIPS32 datapath. It replaces the single-cycle decoder with an 11-state FSM that steps each instruction through fetch, decode, address/execute, memory and write-back. It drives every datapath enable and mux select, and stalls on a memory-ready handshake with a bounded timeout. It sits between the instruction register (`opcode` source) and the shared instruction/data memory port.

## Interface
- `TIMEOUT`, default 255: maximum consecutive memory-wait cycles before abort. 0 disables the timeout. Range 0..255.
- `clk` input 1: clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 6: IR[31:26]. Stable from DECODE until the next IRWrite.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemToReg`, `RegWrite`, `RegDst`, `ALUSrcA` output 1 each: datapath controls.
- `ALUSrcB` output 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` output 2: 00 = add, 01 = subtract, 10 = funct-decoded.
- `PCSource` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` output 4: current state encoding (debug).
- `instr_done` output 1: 1-cycle pulse on the final cycle of a retired instruction.
- `illegal_op` output 1: 1-cycle pulse for an unsupported opcode.
- `mem_timeout` output 1: 1-cycle pulse when a memory wait is aborted.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10. Encodings 11–15 go to IDLE.
- Every output not listed for a state is 0. No X values are driven.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = `mem_ready` (Mealy qualification).
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes the branch target). Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other → FETCH, with `illegal_op`=1 this cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ if opcode=100011, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemToReg=1. Next is FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Waits for `mem_ready`, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALU_WB.
- ALU_WB: RegWrite=1, RegDst=1, MemToReg=0. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next is FETCH.
- `instr_done`=1 in: MEM_WB, ALU_WB, BRANCH, JUMP, and MEM_WRITE when `mem_ready`=1. It is never asserted on an illegal opcode or a timeout.
- Wait counter (8-bit):
  - Cleared on entering FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle spent in one of those states with `mem_ready`=0.
  - If TIMEOUT≠0 and the counter equals TIMEOUT while `mem_ready`=0, the FSM aborts:
    - Next state is FETCH; `mem_timeout`=1 this cycle.
    - IRWrite, PCWrite and write-back are not performed.
    - A FETCH timeout re-enters FETCH with PC unchanged (retry).
  - `mem_ready`=1 in the same cycle as a timeout match: completion wins and no timeout is flagged.

## Timing
- Reset: while `rst_n`=0, state=IDLE, counter=0, all outputs 0. Reset is asynchronous, so it takes effect mid-wait or mid-instruction without completing any pending write.
- The first FETCH is the cycle after reset deasserts plus one IDLE cycle.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready` low adds one cycle.
- Control outputs are a function of the registered state, plus `mem_ready` (IRWrite, PCWrite, `instr_done`, `mem_timeout`) and `opcode` (`illegal_op`).
- Control outputs and `state` change only after a rising edge or on reset assertion.
- The memory request (MemRead/MemWrite with IorD) is held constant for the whole wait.

## Test plan
- Reset, then lw (opcode 100011) with `mem_ready`=1 → states 0,1,2,3,4,5,1. RegWrite=1 and MemToReg=1 only in state 5. `instr_done` pulses once.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → MemWrite=1, IorD=1 held 4 cycles. `instr_done` coincides with `mem_ready`. Next state FETCH.
- R-type, then beq, then j, `mem_ready`=1 → 4+3+3 cycles. PCWriteCond=1 with PCSource=01 in BRANCH. PCWrite=1 with PCSource=10 in JUMP.
- opcode 001000 in DECODE → `illegal_op`=1 for one cycle. Next state FETCH. No RegWrite, MemWrite or `instr_done`.
- TIMEOUT=4, `mem_ready` held 0 in MEM_READ → `mem_timeout` pulses in the 5th wait cycle. Next state FETCH. No MEM_WB.
- `rst_n` dropped during MEM_WRITE wait → state=0 and all outputs 0 immediately. After release, one IDLE cycle then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// ----------------------
// Moore-style sequencer for the multi-cycle MIPS32 datapath. Each instruction
// is stepped through fetch, decode, address/execute, memory and write-back.
// Memory accesses stall on mem_ready. A wait that runs too long is aborted
// back to FETCH.
//
// Parameters
//   TIMEOUT      maximum consecutive memory-wait cycles before abort (0 = never)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   opcode       IR[31:26], stable from DECODE until the next IRWrite
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite .. ALUSrcA   single-bit datapath controls
//   ALUSrcB      00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   ALUOp        00 add, 01 subtract, 10 funct-decoded
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   state        current state encoding (debug)
//   instr_done   pulse on the final cycle of a retired instruction
//   illegal_op   pulse when DECODE sees an unsupported opcode
//   mem_timeout  pulse when a memory wait is aborted
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT_VAL = TIMEOUT[7:0];
    localparam bit         TIMEOUT_ON  = (TIMEOUT != 0);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       wait_state;
    logic       timeout_hit;

    // The three states that issue a memory request are the only ones that
    // can stall. The abort fires only while memory is still not ready, so
    // a completion in the matching cycle always wins.
    assign wait_state  = (cur_state == FETCH) || (cur_state == MEM_READ) ||
                         (cur_state == MEM_WRITE);
    assign timeout_hit = TIMEOUT_ON && wait_state && !mem_ready &&
                         (wait_cnt == TIMEOUT_VAL);

    assign state = cur_state;

    // State register. Reset is asynchronous so an instruction in flight is
    // dropped at once, including any pending memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Wait counter. It counts stalled cycles while a request is outstanding.
    // Leaving a wait state, completing, or aborting all return it to zero.
    // As a result, every entry into a wait state (including the FETCH retry
    // after an abort) starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (wait_state && !mem_ready && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Next-state and control decode. Every control defaults to 0 so each
    // state lists only what it asserts. The mem_ready-qualified strobes keep
    // IR/PC updates and instruction retirement tied to the completing cycle.
    always_comb begin
        next_state  = IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (cur_state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end else begin
                    next_state  = FETCH;
                    mem_timeout = timeout_hit;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default: begin
                        next_state = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state = MEM_WB;
                end else if (timeout_hit) begin
                    next_state  = FETCH;
                    mem_timeout = 1'b1;
                end else begin
                    next_state = MEM_READ;
                end
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                    instr_done = 1'b1;
                end else if (timeout_hit) begin
                    next_state  = FETCH;
                    mem_timeout = 1'b1;
                end else begin
                    next_state = MEM_WRITE;
                end
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = ALU_WB;
            end
            ALU_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                next_state  = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
